fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch front end. Owns the architectural fetch PC and issues one request per cycle to a 1-cycle-latency synchronous instruction memory.
- Queries the gshare/BTB predictor with the current PC to choose the next PC. Accepts mispredict redirects from EX.
- Delivers fetch packets to decode over a valid/ready handshake. A 1-entry skid buffer absorbs the in-flight response when decode stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- imemReq  out  1  fetch request this cycle
- imemAddr  out  32  fetch address; equals pc
- imemRdata  in  32  instruction, valid the cycle after imemReq
- bpPc  out  32  predictor lookup PC; equals pc, combinational
- bpHit  in  1  predictor says taken; same cycle as bpPc
- bpTarget  in  32  predicted target
- exRedirect  in  1  EX mispredict or redirect
- exRedirectPc  in  32  corrected PC
- idValid  out  1  packet valid to decode
- idReady  in  1  decode accepts packet
- idPc  out  32  packet PC
- idInstr  out  32  packet instruction
- idPredTaken  out  1  prediction made at fetch, for EX compare
- idPredTarget  out  32  predicted target, for EX compare

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC; f2Valid=0; skid valid=0; idValid=0; state=RUN.
  - imemReq is combinationally 0 while rst==0.
- Stages:
  - F1: pc register; request issued.
  - F2: f2Valid/f2Pc/f2PredTaken/f2PredTarget registered at issue; instruction taken from imemRdata.
  - OUT: registered packet driving the id* ports.
- canAdv = !idValid || idReady.
- Issue rule: imemReq = rst && !exRedirect && state==RUN && (canAdv || !f2Valid).
- On issue:
  - f2 <= {pc, bpHit, bpTarget}.
  - pc <= bpHit ? bpTarget : pc+4.
- Without issue: pc holds; f2Valid <= 0.
- State RUN (skid empty):
  - canAdv && f2Valid: OUT <= f2 packet with imemRdata.
  - canAdv && !f2Valid: idValid <= 0.
  - !canAdv && f2Valid: skid <= f2 packet with imemRdata; state <= SKID. No issue this cycle, so f2Valid is 0 in SKID.
- State SKID:
  - No issue.
  - When canAdv: OUT <= skid; skid valid <= 0; state <= RUN.
- exRedirect has highest priority, above stall and bpHit:
  - pc <= {exRedirectPc[31:2], 2'b00}.
  - f2Valid, skid valid and idValid cleared; state <= RUN; no issue that cycle.
  - Redirect cycle c. Request at c+1, data at c+2. idValid=1 with idPc=redirect PC in cycle c+3.
- Steady-state throughput: 1 packet/cycle. Sequential fetch latency pc -> idValid is 2 cycles.
- pc+4 wraps modulo 2^32. pc[1:0] is always 00.
- A packet held under idReady=0 keeps all id* outputs stable until accepted.

Decomposition:
- Shared package fetch_pkg:
  - typedef struct packed fetch_pkt_t {pc, instr, predTaken, predTarget}.
  - enum fetch_state_t {RUN, SKID}.
  - localparam INSTR_BYTES=4.
- Natural sub-module: fetch_skid_buf. Holds a 1-entry fetch_pkt_t with load/unload/flush and a valid flag; also owns the RUN/SKID state.

Test Plan:
- Reset release with RESET_PC=0, idReady=1, bpHit=0 -> imemAddr 0,4,8,... on consecutive cycles. idValid rises 2 cycles after the first request; idPc sequence 0,4,8.
- bpHit=1, bpTarget=0x100 while pc=0x8 -> next imemAddr=0x100. Packet 0x8 delivered with idPredTaken=1, idPredTarget=0x100.
- idReady=0 for 3 cycles while streaming:
  - Exactly one packet enters the skid; imemReq=0 during the stall.
  - After release, packets arrive in order with none lost or duplicated, and id* stays stable while stalled.
- exRedirect=1, exRedirectPc=0x203, during a SKID stall -> idValid=0 next cycle, skid flushed. Next request is 0x200; idPc=0x200 three cycles after the redirect.
- exRedirect and bpHit in the same cycle -> redirect wins; no request issued to bpTarget.
- rst=0 asserted mid-stream with idValid=1 and skid full -> next cycle idValid=0, skid empty, pc=RESET_PC, imemReq=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: fetch packet layout,
// skid-buffer state encoding and instruction size.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  pred_taken;
        logic [FETCH_XLEN-1:0] pred_target;
    } fetch_pkt_t;

    typedef enum logic {
        RUN  = 1'b0,
        SKID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding the memory response that arrives while
// decode is stalled; its RUN/SKID state gates new fetch requests.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  fetch_pkt_t   load_pkt,
    output logic         valid,
    output fetch_pkt_t   pkt,
    output fetch_state_t state
);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state <= RUN;
            valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (load) begin
                        pkt   <= load_pkt;
                        valid <= 1'b1;
                        state <= SKID;
                    end
                end
                SKID: begin
                    if (unload) begin
                        valid <= 1'b0;
                        state <= RUN;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC register (F1), 1-cycle memory response (F2)
// and a registered output packet to decode, with a skid buffer for stalls.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] bpPc,
    input  logic            bpHit,
    input  logic [XLEN-1:0] bpTarget,
    input  logic            exRedirect,
    input  logic [XLEN-1:0] exRedirectPc,
    output logic            idValid,
    input  logic            idReady,
    output logic [XLEN-1:0] idPc,
    output logic [XLEN-1:0] idInstr,
    output logic            idPredTaken,
    output logic [XLEN-1:0] idPredTarget
);

    logic [XLEN-1:0] pc;
    logic            f2_valid;
    logic [XLEN-1:0] f2_pc;
    logic            f2_pred_taken;
    logic [XLEN-1:0] f2_pred_target;
    logic            out_valid;
    fetch_pkt_t      out_pkt;
    fetch_pkt_t      f2_pkt;
    fetch_pkt_t      skid_pkt;
    logic            skid_valid;
    fetch_state_t    state;
    logic            can_adv;
    logic            issue;
    logic            skid_load;
    logic            skid_unload;

    always_comb begin
        can_adv     = !out_valid || idReady;
        issue       = rst && !exRedirect && (state == RUN) && (can_adv || !f2_valid);
        skid_load   = rst && !exRedirect && (state == RUN) && !can_adv && f2_valid;
        skid_unload = (state == SKID) && can_adv;
        f2_pkt      = '{pc:          f2_pc,
                        instr:       imemRdata,
                        pred_taken:  f2_pred_taken,
                        pred_target: f2_pred_target};
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (exRedirect),
        .load_pkt (f2_pkt),
        .valid    (skid_valid),
        .pkt      (skid_pkt),
        .state    (state)
    );

    // Redirect outranks stall and prediction; everything in flight is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            f2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (exRedirect) begin
            pc        <= {exRedirectPc[XLEN-1:2], 2'b00};
            f2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            f2_valid <= issue;
            if (issue) begin
                f2_pc          <= pc;
                f2_pred_taken  <= bpHit;
                f2_pred_target <= bpTarget;
                pc             <= bpHit ? bpTarget : pc + XLEN'(INSTR_BYTES);
            end
            if (can_adv) begin
                if (skid_valid) begin
                    out_pkt   <= skid_pkt;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= f2_valid;
                    if (f2_valid) begin
                        out_pkt <= f2_pkt;
                    end
                end
            end
        end
    end

    assign imemReq      = issue;
    assign imemAddr     = pc;
    assign bpPc         = pc;
    assign idValid      = out_valid;
    assign idPc         = out_pkt.pc;
    assign idInstr      = out_pkt.instr;
    assign idPredTaken  = out_pkt.pred_taken;
    assign idPredTarget = out_pkt.pred_target;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, with a packet-stream scoreboard watching every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] bpPc;
    logic        bpHit;
    logic [31:0] bpTarget;
    logic        exRedirect;
    logic [31:0] exRedirectPc;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [31:0] idInstr;
    logic        idPredTaken;
    logic [31:0] idPredTarget;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemRdata    (imemRdata),
        .bpPc         (bpPc),
        .bpHit        (bpHit),
        .bpTarget     (bpTarget),
        .exRedirect   (exRedirect),
        .exRedirectPc (exRedirectPc),
        .idValid      (idValid),
        .idReady      (idReady),
        .idPc         (idPc),
        .idInstr      (idInstr),
        .idPredTaken  (idPredTaken),
        .idPredTarget (idPredTarget)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imemReq) imemRdata <= mem_word(imemAddr);
    end

    // Scoreboard: every issued request becomes one expected packet, delivered in order.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    exp_t        held;
    logic [31:0] mpc;
    logic        hold_prev = 1'b0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            n_checks++;
            if (imemReq !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_reset_req: imemReq=%b required 0", imemReq);
            end
            sb.delete();
            mpc       = RESET_PC;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                n_checks++;
                if (idValid !== 1'b1 || idPc !== held.pc || idInstr !== held.instr ||
                    idPredTaken !== held.taken || idPredTarget !== held.target) begin
                    n_fail++;
                    $display("FAIL sb_stable: got v=%b pc=%h instr=%h required pc=%h instr=%h",
                             idValid, idPc, idInstr, held.pc, held.instr);
                end
            end
            if (idValid === 1'b1 && idReady === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: packet pc=%h delivered, none outstanding", idPc);
                end else begin
                    e = sb.pop_front();
                    if (idPc !== e.pc || idInstr !== e.instr ||
                        idPredTaken !== e.taken || idPredTarget !== e.target) begin
                        n_fail++;
                        $display("FAIL sb_pkt: got pc=%h instr=%h tk=%b tgt=%h required pc=%h instr=%h tk=%b tgt=%h",
                                 idPc, idInstr, idPredTaken, idPredTarget, e.pc, e.instr, e.taken, e.target);
                    end
                end
            end
            hold_prev = (idValid === 1'b1) && !idReady && !exRedirect;
            held      = '{pc: idPc, instr: idInstr, taken: idPredTaken, target: idPredTarget};
            if (exRedirect) begin
                n_checks++;
                if (imemReq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_redirect_req: imemReq=%b required 0", imemReq);
                end
                sb.delete();
                mpc = {exRedirectPc[31:2], 2'b00};
            end else if (imemReq === 1'b1) begin
                n_checks++;
                if (imemAddr !== mpc || bpPc !== mpc) begin
                    n_fail++;
                    $display("FAIL sb_addr: imemAddr=%h bpPc=%h required %h", imemAddr, bpPc, mpc);
                end
                sb.push_back('{pc: mpc, instr: mem_word(mpc), taken: bpHit, target: bpTarget});
                mpc = bpHit ? bpTarget : mpc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        idReady = 1'b1; bpHit = 1'b0; exRedirect = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; idReady = 1'b1; bpHit = 1'b0; bpTarget = '0;
        exRedirect = 1'b0; exRedirectPc = '0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0 || imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: idValid=%b imemReq=%b required 0 0", idValid, imemReq);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (imemReq !== 1'b1 || imemAddr !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL reset_seq_addr[%0d]: req=%b addr=%h required 1 %h", k, imemReq, imemAddr, 32'(4 * k));
            end
            n_checks++;
            if (k < 2) begin
                if (idValid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_seq_idvalid[%0d]: idValid=%b required 0", k, idValid);
                end
            end else if (idValid !== 1'b1 || idPc !== 32'(4 * (k - 2)) || idInstr !== mem_word(32'(4 * (k - 2)))) begin
                n_fail++;
                $display("FAIL reset_seq_pkt[%0d]: v=%b pc=%h required 1 %h", k, idValid, idPc, 32'(4 * (k - 2)));
            end
            tick();
        end
    endtask

    task automatic test_bp_hit();
        rst = 1'b0; tick();
        rst = 1'b1; tick();
        tick();
        bpHit = 1'b1; bpTarget = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_pre_addr: req=%b addr=%h required 1 00000008", imemReq, imemAddr);
        end
        tick();
        bpHit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin
            n_fail++;
            $display("FAIL bp_target_addr: req=%b addr=%h required 1 00000100", imemReq, imemAddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== 32'h8 || idPredTaken !== 1'b1 || idPredTarget !== 32'h100) begin
            n_fail++;
            $display("FAIL bp_pkt: v=%b pc=%h tk=%b tgt=%h required 1 00000008 1 00000100",
                     idValid, idPc, idPredTaken, idPredTarget);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== 32'h100 || idPredTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_pkt: v=%b pc=%h tk=%b required 1 00000100 0", idValid, idPc, idPredTaken);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] p;
        stream(3);
        idReady = 1'b0;
        @(negedge clk);
        p = idPc;
        n_checks++;
        if (idValid !== 1'b1 || imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_enter: v=%b req=%b required 1 0", idValid, imemReq);
        end
        for (int k = 1; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (imemReq !== 1'b0 || idValid !== 1'b1 || idPc !== p || imemAddr !== p + 32'd8) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b v=%b pc=%h addr=%h required 0 1 %h %h",
                         k, imemReq, idValid, idPc, imemAddr, p, p + 32'd8);
            end
        end
        tick();
        idReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== p || imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: v=%b pc=%h req=%b required 1 %h 0", idValid, idPc, imemReq, p);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== p + 32'd4) begin
            n_fail++;
            $display("FAIL stall_skid_out: v=%b pc=%h required 1 %h", idValid, idPc, p + 32'd4);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bubble: v=%b required 0", idValid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== p + 32'd8) begin
            n_fail++;
            $display("FAIL stall_resume: v=%b pc=%h required 1 %h", idValid, idPc, p + 32'd8);
        end
        tick();
    endtask

    task automatic test_redirect_skid();
        stream(3);
        idReady = 1'b0;
        tick();
        exRedirect = 1'b1; exRedirectPc = 32'h0000_0203;
        tick();
        exRedirect = 1'b0; idReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_c1: v=%b req=%b addr=%h required 0 1 00000200", idValid, imemReq, imemAddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_c2: v=%b required 0", idValid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== 32'h200 || idInstr !== mem_word(32'h200)) begin
            n_fail++;
            $display("FAIL redir_c3: v=%b pc=%h required 1 00000200", idValid, idPc);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== 32'h204) begin
            n_fail++;
            $display("FAIL redir_c4: v=%b pc=%h required 1 00000204", idValid, idPc);
        end
        tick();
    endtask

    task automatic test_redirect_vs_bp();
        stream(3);
        exRedirect = 1'b1; exRedirectPc = 32'h0000_0400;
        bpHit = 1'b1; bpTarget = 32'h0000_0800;
        tick();
        exRedirect = 1'b0; bpHit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h400) begin
            n_fail++;
            $display("FAIL rvb_first: req=%b addr=%h required 1 00000400", imemReq, imemAddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (imemAddr !== 32'h404) begin
            n_fail++;
            $display("FAIL rvb_second: addr=%h required 00000404", imemAddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== 32'h400 || idPredTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL rvb_pkt: v=%b pc=%h tk=%b required 1 00000400 0", idValid, idPc, idPredTaken);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        stream(3);
        idReady = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstm_pre: v=%b required 1", idValid);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL rstm_req_comb: req=%b required 0", imemReq);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0 || imemReq !== 1'b0 || imemAddr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rstm_state: v=%b req=%b addr=%h required 0 0 %h", idValid, imemReq, imemAddr, RESET_PC);
        end
        tick();
        rst = 1'b1; idReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rstm_restart: v=%b req=%b addr=%h required 0 1 %h", idValid, imemReq, imemAddr, RESET_PC);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstm_skid_empty: v=%b required 0", idValid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (idValid !== 1'b1 || idPc !== RESET_PC) begin
            n_fail++;
            $display("FAIL rstm_first_pkt: v=%b pc=%h required 1 %h", idValid, idPc, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 500; i++) begin
            idReady    = ($urandom_range(0, 3) != 0);
            bpHit      = ($urandom_range(0, 4) == 0);
            r          = $urandom;
            bpTarget   = {r[31:2], 2'b00};
            exRedirect = ($urandom_range(0, 29) == 0);
            exRedirectPc = $urandom;
            tick();
        end
        stream(6);
    endtask

    initial begin
        test_reset();
        test_bp_hit();
        test_stall();
        test_redirect_skid();
        test_redirect_vs_bp();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
